// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with a registered output stage and a
// round-robin or fixed-priority arbiter. Define STREAM_MUX_FORCE_SEL_EN to add force_en/force_sel.
module stream_mux_rr #(
  parameter int WIDTH     = 4,
  parameter int N_CH      = 4,
  parameter int CH_W      = $clog2(N_CH),
  parameter int PRIO_MODE = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         in_valid,
  input  logic [N_CH*WIDTH-1:0]   in_data,
  output logic [N_CH-1:0]         in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]         out_ch,
  input  logic                    out_ready
`ifdef STREAM_MUX_FORCE_SEL_EN
  ,
  input  logic                    force_en,
  input  logic [CH_W-1:0]         force_sel
`endif
);

  logic              r_valid;
  logic [WIDTH-1:0]  r_data;
  logic [CH_W-1:0]   r_ch;
  logic [CH_W-1:0]   r_ptr;

  logic              w_load;
  logic              w_any;
  logic              w_forced;
  logic              w_xfer;
  logic              w_hi_found;
  logic              w_lo_found;
  logic [CH_W-1:0]   w_hi_idx;
  logic [CH_W-1:0]   w_lo_idx;
  logic [CH_W-1:0]   w_win;
  logic [CH_W-1:0]   w_ptr_nxt;
  logic [N_CH-1:0]   w_grant;
  logic [WIDTH-1:0]  w_data;

  assign w_load = !r_valid | out_ready;

  // Lowest requester at or above the pointer wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        w_lo_found = 1'b1;
        w_lo_idx   = CH_W'(i);
        if (i >= int'(r_ptr)) begin
          w_hi_found = 1'b1;
          w_hi_idx   = CH_W'(i);
        end
      end
    end
    w_win    = (PRIO_MODE == 0 && w_hi_found) ? w_hi_idx : w_lo_idx;
    w_any    = w_lo_found;
    w_forced = 1'b0;
`ifdef STREAM_MUX_FORCE_SEL_EN
    if (force_en) begin
      w_forced = 1'b1;
      w_win    = force_sel;
      w_any    = int'(force_sel) < N_CH;
    end
`endif
  end

  always_comb begin
    w_grant = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_grant[i] = w_load & w_any & (w_win == CH_W'(i));
    end
  end

  assign in_ready = rst_n ? w_grant : '0;
  assign w_xfer   = |(in_valid & in_ready);

  // One-hot data select keeps non-granted channels (possibly X) off the output.
  always_comb begin
    w_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (in_ready[i] & in_valid[i]) begin
        w_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_ptr_nxt = (w_win == CH_W'(N_CH - 1)) ? '0 : w_win + CH_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ch    <= '0;
      r_ptr   <= '0;
    end else begin
      if (w_load) begin
        if (w_xfer) begin
          r_valid <= 1'b1;
          r_data  <= w_data;
          r_ch    <= w_win;
        end else begin
          r_valid <= 1'b0;
        end
      end
      if (w_xfer && !w_forced) begin
        r_ptr <= w_ptr_nxt;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_ch    = r_ch;

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
Parametrised N-channel streaming multiplexer, the successor to the combinational 4:1 mux. Each input channel has a valid/ready handshake. An arbiter picks one requesting channel per cycle: round-robin or fixed-priority, chosen by parameter. The winner's word is registered into a single output stage with valid/ready. It sits between multiple producers and one shared consumer, such as a shared bus or a shared FIFO write port.

Parameters:
- WIDTH, 4: data width of every channel in bits
- N_CH, 4: number of input channels, ≥2
- CH_W, $clog2(N_CH): width of channel index
- PRIO_MODE, 0: 0 = round-robin arbitration, 1 = fixed priority (lowest index wins)

Ports:
- clk, input, 1: clock, rising edge
- rst_n, input, 1: asynchronous active-low reset
- in_valid, input, N_CH: per-channel valid
- in_data, input, N_CH*WIDTH: packed channel data; channel i at [i*WIDTH +: WIDTH]
- in_ready, output, N_CH: per-channel ready; at most one bit set
- out_valid, output, 1: output word valid
- out_data, output, WIDTH: output word
- out_ch, output, CH_W: index of the channel that supplied out_data
- out_ready, input, 1: consumer ready

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_ch=0, round-robin pointer ptr=0. in_ready=0 while rst_n is low.
- Output register update: load = !out_valid | out_ready.
- Arbitration is combinational over in_valid.
  - PRIO_MODE=0: winner is the first channel with in_valid set, scanning ptr, ptr+1, …, N_CH-1, 0, …, ptr-1 (wrap-around).
  - PRIO_MODE=1: winner is the lowest set index.
- in_ready[i] = load & (i == winner) & (|in_valid). in_ready is one-hot or zero, with no combinational path from in_data.
- Transfer on channel i occurs when in_valid[i] & in_ready[i]. On the next edge: out_data=in_data[i], out_ch=i, out_valid=1.
- Latency: 1 cycle from accept to out_valid.
- Full throughput: one word per cycle when out_ready is held at 1.
- Output drain: if load=1 and no in_valid is set, out_valid goes to 0 at the next edge. out_data and out_ch hold their last value.
- Stall: while out_valid=1 and out_ready=0, out_valid, out_data and out_ch are stable and all in_ready bits are 0.
- Round-robin pointer:
  - Updates only on a transfer: ptr = (winner == N_CH-1) ? 0 : winner+1.
  - Does not move on idle or stall cycles.
  - Ignored when PRIO_MODE=1.
- Inputs must not be held off indefinitely: under PRIO_MODE=0, a channel holding in_valid wins within N_CH transfers.
- Simultaneous drain and refill (out_valid=1, out_ready=1, a requester present): the old word is consumed and the new word is loaded on the same edge. There is no bubble.
- Reset mid-stream: the pending output word is discarded and the pointer returns to 0. Producers must re-present their words; in_valid dropping during reset is legal.
- in_valid[i] may deassert without a transfer; the arbiter re-evaluates every cycle.
- X on in_data of a non-winning channel must not propagate to out_data.

Optional Feature:
- Macro: STREAM_MUX_FORCE_SEL_EN
- Defined: adds ports force_en (input, 1) and force_sel (input, CH_W). While force_en=1:
  - winner = force_sel, regardless of arbitration mode.
  - in_ready[force_sel] = load.
  - All other in_ready bits are 0.
  - ptr is not updated.
  - force_sel ≥ N_CH selects nothing: all in_ready are 0.
- Undefined: the ports are absent and behaviour is arbitration only.

Test Plan:
- Reset: assert rst_n=0 mid-transfer with out_valid=1 → out_valid=0, out_data=0, out_ch=0, in_ready=0 immediately, without waiting for a clock edge; after release the first grant goes to ch0 when all channels are valid.
- Round-robin fairness (N_CH=4, WIDTH=4, PRIO_MODE=0): in_data = {d,c,b,a} (ch3 in the top field), so ch0=a, ch1=b, ch2=c, ch3=d; all in_valid=1, out_ready=1 → out_data sequence a,b,c,d,a and out_ch 0,1,2,3,0 on consecutive cycles.
- Fixed priority (PRIO_MODE=1): in_valid=4'b1010, out_ready=1 → ch1 wins every cycle; ch3 wins only after in_valid[1] drops.
- Backpressure: accept 'h7 from ch2, then out_ready=0 for 3 cycles → out_valid=1, out_data=7, out_ch=2 stable and in_ready=0 throughout; then out_ready=1 → next word loads on the same edge.
- Sparse traffic: only ch3 valid with data 'hA for one cycle, then idle → out_data=A, out_ch=3 for one cycle; out_valid=0 afterwards; next all-valid grant goes to ch0 (ptr wrapped).
- STREAM_MUX_FORCE_SEL_EN: force_en=1, force_sel=2, all valid → only in_ready[2] is set; out_ch=2 every cycle; after force_en=0 round-robin resumes from the pointer held before forcing.
